delta_consolidation_arbiter: RTL and testbench
==============================================

// Module: delta_consolidation_arbiter
// PURPOSE
//   Shares one episode-memory write port among N_REQ theta-episode buffers.
//   Each delta_tick (topic boundary, from the delta oscillator) opens a
//   consolidation window of WIN_CYCLES clocks. Inside the window, requesters get
//   round-robin bursts of memory beats, capped at MAX_BURST beats per grant.
//   Sits between the oscillator hierarchy and the shared episode memory.
// PARAMETERS
//   N_REQ      4   number of requesters (2..8)
//   LEN_W      4   width of each requester's pending-beat count
//   MAX_BURST  8   max beats per grant (1..2^LEN_W-1)
//   WIN_CYCLES 64  window length in clocks (>= 4)
//   AGE_LIMIT  3   missed windows before priority boost (CONSOL_AGING_EN only)
// PORTS
//   clk         in   1            system clock
//   rst         in   1            synchronous, active-high reset
//   delta_tick  in   1            1-clk topic-boundary pulse; opens window
//   req         in   N_REQ        requester i has pending beats
//   req_len     in   N_REQ*LEN_W  pending beats, slice i = [i*LEN_W +: LEN_W]
//   mem_ready   in   1            memory accepts a beat this cycle
//   gnt         out  N_REQ        one-hot grant (registered)
//   beat_cnt    out  LEN_W        beats accepted in the current grant
//   window_open out  1            consolidation window active
//   busy        out  1            a grant is active
//   overrun     out  1            sticky: delta_tick arrived while window open
// BEHAVIOUR
//   Reset: gnt=0, beat_cnt=0, window_open=0, busy=0, overrun=0, rr_ptr=0, FSM=IDLE.
//   Window: delta_tick at cycle t -> window_open=1 for cycles t+1..t+WIN_CYCLES.
//     A down-counter loads WIN_CYCLES-1 at t+1. window_open falls when it reaches 0.
//   FSM: IDLE -> ARB on delta_tick.
//     ARB: pick the first i with req[i]&&req_len_i!=0, scanning from rr_ptr
//       upward (mod N_REQ). Set gnt[i], busy=1 next cycle -> GRANT.
//       If there is no eligible requester, stay in ARB and re-scan every cycle.
//     GRANT: a beat is accepted on any cycle with gnt[i]&&mem_ready.
//       beat_cnt increments, saturating at MAX_BURST.
//       The burst ends when beat_cnt reaches min(req_len_i latched at grant, MAX_BURST).
//       It also ends if req[i] drops, or if window_open falls.
//       On end: gnt=0 and busy=0 next cycle, rr_ptr=i+1 mod N_REQ -> GAP.
//     GAP: 1 turnaround cycle with no grant; beat_cnt cleared -> ARB.
//       If the window is closed, go to IDLE instead.
//     ARB/GAP with window closed -> IDLE.
//   Grant latency: delta_tick at t, eligible req -> gnt at t+2.
//     Back-to-back grants are separated by exactly 1 idle cycle (GAP).
//   A beat on the last open cycle is accepted. gnt is low from the first closed cycle.
//   delta_tick while window_open: counter reloads (window extended), overrun<=1.
//     The current burst is not interrupted. overrun clears only on rst.
//   delta_tick coinciding with the final open cycle: window stays open (reload wins).
//   req_len_i==0 with req[i]=1: not eligible, skipped.
//   rst mid-burst: all outputs return to reset values on the next edge. The beat is lost.
// CONFIGURATION
//   CONSOL_AGING_EN defined:
//     A per-requester counter increments at each window close if the requester
//       was eligible but ungranted in that window. It clears when the requester is granted.
//     In ARB, any requester with age >= AGE_LIMIT wins over rr_ptr order.
//       Among aged requesters, the lowest index wins. rr_ptr is still updated after the grant.
//     Age counters reset to 0.
//   CONSOL_AGING_EN undefined: pure round-robin; no age logic is synthesised.
// TESTING
//   1 rst=1 for 2 clk, then release -> all outputs 0, no gnt even with req=4'b1111.
//   2 delta_tick@t, req=4'b0010, len1=3, mem_ready=1 -> gnt=0010 t+2..t+4,
//     beat_cnt 1,2,3; gnt=0 at t+5.
//   3 req=4'b1111, all len=2, mem_ready=1 -> grant order 0,1,2,3,0.
//     One idle cycle between grants.
//   4 len0=15, MAX_BURST=8 -> 8 beats, then release.
//     Requester 1 is granted before requester 0 is granted again.
//   5 WIN_CYCLES=8, continuous long bursts -> window_open high exactly 8 cycles.
//     gnt=0 on the 9th cycle; FSM reaches IDLE.
//   6 second delta_tick 5 cycles into the window -> overrun=1.
//     Window runs WIN_CYCLES cycles past the second tick. The burst continues unbroken.

Source files
------------

// File: rtl/delta_consolidation_arbiter.sv
// Round-robin burst arbiter sharing one episode-memory write port inside delta windows.
// Optional aging priority boost is built when CONSOL_AGING_EN is defined.
module delta_consolidation_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned WIN_CYCLES = 64,
  parameter int unsigned AGE_LIMIT  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   delta_tick,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic                   mem_ready,
  output logic [N_REQ-1:0]       gnt,
  output logic [LEN_W-1:0]       beat_cnt,
  output logic                   window_open,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SumW = IdxW + 1;
  localparam int unsigned CntW = $clog2(WIN_CYCLES);
  localparam logic [LEN_W-1:0] MaxB = LEN_W'(MAX_BURST);
  localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

  typedef enum logic [1:0] {StIdle, StArb, StGrant, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   win_cnt_q, win_cnt_d;
  logic              window_open_q, window_open_d;
  logic              overrun_q, overrun_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]  lim_q, lim_d;

  logic [N_REQ-1:0]  elig;
  logic [LEN_W-1:0]  len_arr [N_REQ];
  logic              found;
  logic [IdxW-1:0]   pick;
  logic              grant_now;
  logic              burst_end;
  logic              closing;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      len_arr[i] = req_len[i*LEN_W +: LEN_W];
      elig[i]    = req[i] && (len_arr[i] != '0);
    end
  end

  // A tick always reloads, so a tick on the final open cycle keeps the window open.
  always_comb begin
    window_open_d = window_open_q;
    win_cnt_d     = win_cnt_q;
    overrun_d     = overrun_q;
    if (delta_tick) begin
      window_open_d = 1'b1;
      win_cnt_d     = CntW'(WIN_CYCLES - 1);
      if (window_open_q) overrun_d = 1'b1;
    end else if (window_open_q) begin
      if (win_cnt_q == '0) window_open_d = 1'b0;
      else                 win_cnt_d = win_cnt_q - 1'b1;
    end
  end

  assign closing = window_open_q && !window_open_d;

`ifdef CONSOL_AGING_EN
  localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
  logic [AgeW-1:0]  age_q [N_REQ];
  logic [AgeW-1:0]  age_d [N_REQ];
  logic [N_REQ-1:0] seen_elig_q, seen_elig_d, seen_gnt_q, seen_gnt_d;
  logic [N_REQ-1:0] aged;

  always_comb begin
    aged = '0;
    for (int i = 0; i < N_REQ; i++) aged[i] = elig[i] && (age_q[i] >= AgeW'(AGE_LIMIT));
  end
`endif

  always_comb begin
    logic [SumW-1:0] sum;
    sum   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (sum >= SumW'(N_REQ)) sum = sum - SumW'(N_REQ);
      if (!found && elig[sum[IdxW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IdxW-1:0];
      end
    end
`ifdef CONSOL_AGING_EN
    // Starved requesters override round-robin order; lowest index among them wins.
    if (|aged) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (aged[i]) pick = IdxW'(i);
      end
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    lim_d      = lim_q;
    grant_now  = 1'b0;
    burst_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (delta_tick) state_d = StArb;
      end
      // GAP arbitrates too, so consecutive grants are separated by one idle cycle.
      StArb, StGap: begin
        gnt_d      = '0;
        busy_d     = 1'b0;
        beat_cnt_d = '0;
        if (!window_open_q) begin
          state_d = StIdle;
        end else if (found && window_open_d) begin
          grant_now = 1'b1;
          state_d   = StGrant;
          gnt_d     = OneHot0 << pick;
          busy_d    = 1'b1;
          idx_d     = pick;
          lim_d     = (len_arr[pick] > MaxB) ? MaxB : len_arr[pick];
        end else begin
          state_d = StArb;
        end
      end
      StGrant: begin
        if (mem_ready && (beat_cnt_q < MaxB)) beat_cnt_d = beat_cnt_q + 1'b1;
        burst_end = (mem_ready && (beat_cnt_d >= lim_q)) || !req[idx_q] || !window_open_d;
        if (burst_end) begin
          state_d  = StGap;
          gnt_d    = '0;
          busy_d   = 1'b0;
          rr_ptr_d = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CONSOL_AGING_EN
  always_comb begin
    seen_elig_d = seen_elig_q | (window_open_q ? elig : '0);
    seen_gnt_d  = seen_gnt_q;
    if (grant_now) seen_gnt_d[pick] = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      age_d[i] = age_q[i];
      if (closing && seen_elig_d[i] && !seen_gnt_d[i] && (age_q[i] < AgeW'(AGE_LIMIT))) begin
        age_d[i] = age_q[i] + 1'b1;
      end
      if (grant_now && (pick == IdxW'(i))) age_d[i] = '0;
    end
    if (closing) begin
      seen_elig_d = '0;
      seen_gnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_elig_q <= '0;
      seen_gnt_q  <= '0;
      for (int i = 0; i < N_REQ; i++) age_q[i] <= '0;
    end else begin
      seen_elig_q <= seen_elig_d;
      seen_gnt_q  <= seen_gnt_d;
      for (int i = 0; i < N_REQ; i++) age_q[i] <= age_d[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      win_cnt_q     <= '0;
      window_open_q <= 1'b0;
      overrun_q     <= 1'b0;
      gnt_q         <= '0;
      beat_cnt_q    <= '0;
      busy_q        <= 1'b0;
      rr_ptr_q      <= '0;
      idx_q         <= '0;
      lim_q         <= '0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      window_open_q <= window_open_d;
      overrun_q     <= overrun_d;
      gnt_q         <= gnt_d;
      beat_cnt_q    <= beat_cnt_d;
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
      idx_q         <= idx_d;
      lim_q         <= lim_d;
    end
  end

  assign gnt         = gnt_q;
  assign beat_cnt    = beat_cnt_q;
  assign window_open = window_open_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_delta_consolidation_arbiter.sv
// Directed and randomized checks of delta_consolidation_arbiter; a second instance
// uses an 8-cycle window for the window-length boundary cases.
module tb_delta_consolidation_arbiter;

  logic        clk = 1'b0;
  logic        rst, delta_tick, mem_ready;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  gnt, gnt8, beat_cnt, beat_cnt8;
  logic        window_open, window_open8, busy, busy8, overrun, overrun8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delta_consolidation_arbiter #(
    .N_REQ(4), .LEN_W(4), .MAX_BURST(8), .WIN_CYCLES(64), .AGE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst), .delta_tick(delta_tick), .req(req), .req_len(req_len),
    .mem_ready(mem_ready), .gnt(gnt), .beat_cnt(beat_cnt), .window_open(window_open),
    .busy(busy), .overrun(overrun)
  );

  delta_consolidation_arbiter #(
    .N_REQ(4), .LEN_W(4), .MAX_BURST(8), .WIN_CYCLES(8), .AGE_LIMIT(3)
  ) dut8 (
    .clk(clk), .rst(rst), .delta_tick(delta_tick), .req(req), .req_len(req_len),
    .mem_ready(mem_ready), .gnt(gnt8), .beat_cnt(beat_cnt8), .window_open(window_open8),
    .busy(busy8), .overrun(overrun8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    delta_tick = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] exp_g [0:70];
  logic       rdy [0:70];
  int         lens [4];
  logic [3:0] t3 [14];
  logic [3:0] t4 [13];

  initial begin
    req = 4'b1111; req_len = 16'h2222; mem_ready = 1'b1;

    // 1: reset state, no grant without a tick
    do_reset();
    chk("rst_gnt", gnt, 0);         chk("rst_beat", beat_cnt, 0);
    chk("rst_win", window_open, 0); chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);     chk("rst_gnt8", gnt8, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
    end

    // 2: single requester, 3 beats, grant latency 2
    do_reset();
    req = 4'b0010; req_len = 16'h0030; mem_ready = 1'b1;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    chk("t2_win_c1", window_open, 1); chk("t2_gnt_c1", gnt, 0);
    tick(); chk("t2_gnt_c2", gnt, 4'b0010); chk("t2_busy_c2", busy, 1);
    tick(); chk("t2_gnt_c3", gnt, 4'b0010); chk("t2_beat_c3", beat_cnt, 1);
    tick(); chk("t2_gnt_c4", gnt, 4'b0010); chk("t2_beat_c4", beat_cnt, 2);
    tick(); chk("t2_gnt_c5", gnt, 0); chk("t2_beat_c5", beat_cnt, 3); chk("t2_busy_c5", busy, 0);
    req = 4'b0000;
    tick(); chk("t2_beat_c6", beat_cnt, 0); chk("t2_gnt_c6", gnt, 0);

    // 3: round-robin order 0,1,2,3,0 with one idle cycle between grants
    t3 = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    do_reset();
    req = 4'b1111; req_len = 16'h2222; mem_ready = 1'b1;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    tick();
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("t3_gnt_c%0d", k + 2), gnt, t3[k]);
      tick();
    end

    // 4: burst capped at MAX_BURST, requester 1 served before 0 again
    t4 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h1};
    do_reset();
    req = 4'b0011; req_len = 16'h002F; mem_ready = 1'b1;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    tick();
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("t4_gnt_c%0d", k + 2), gnt, t4[k]);
      if (k == 8) chk("t4_beat_cap", beat_cnt, 8);
      tick();
    end

    // 5: 8-cycle window cuts a long burst; gnt low from the first closed cycle
    do_reset();
    req = 4'b0001; req_len = 16'h000F; mem_ready = 1'b1;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("t5_win_c%0d", k), window_open8, (k <= 8) ? 1 : 0);
      chk($sformatf("t5_gnt_c%0d", k), gnt8, (k >= 2 && k <= 8) ? 1 : 0);
      tick();
    end
    chk("t5_busy_end", busy8, 0);

    // 6: second tick mid-burst extends the window and sets overrun
    do_reset();
    req = 4'b0001; req_len = 16'h000F; mem_ready = 1'b1;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    for (int k = 1; k <= 71; k++) begin
      delta_tick = (k == 5);
      if (k >= 2 && k <= 9) chk($sformatf("t6_burst_c%0d", k), gnt, 4'b0001);
      if (k == 10) chk("t6_gnt_c10", gnt, 0);
      if (k == 5)  chk("t6_ovr_c5", overrun, 0);
      if (k == 6)  chk("t6_ovr_c6", overrun, 1);
      if (k == 69) chk("t6_win_c69", window_open, 1);
      if (k == 70) chk("t6_win_c70", window_open, 0);
      if (k >= 70) chk($sformatf("t6_gnt_c%0d", k), gnt, 0);
      if (k == 71) chk("t6_ovr_sticky", overrun, 1);
      tick();
    end
    delta_tick = 1'b0;

    // 7: tick on the final open cycle keeps the window open
    do_reset();
    req = 4'b0000;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      delta_tick = (k == 8);
      if (k == 8)  chk("t7_win_c8", window_open8, 1);
      if (k == 9)  begin chk("t7_win_c9", window_open8, 1); chk("t7_ovr_c9", overrun8, 1); end
      if (k == 16) chk("t7_win_c16", window_open8, 1);
      if (k == 17) chk("t7_win_c17", window_open8, 0);
      tick();
    end
    delta_tick = 1'b0;

    // 8: reset mid-burst
    do_reset();
    req = 4'b0001; req_len = 16'h000F; mem_ready = 1'b1;
    delta_tick = 1'b1; tick(); delta_tick = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t8_gnt", gnt, 0); chk("t8_busy", busy, 0); chk("t8_beat", beat_cnt, 0);
    chk("t8_win", window_open, 0); chk("t8_ovr", overrun, 0);

    // Randomized: stable requests, random lengths and mem_ready, scheduled by a model
    for (int trial = 0; trial < 4; trial++) begin
      int c, ptr, i, lim, beats, kk;
      logic found;
      do_reset();
      req = 4'($urandom_range(0, 15));
      for (int r = 0; r < 4; r++) begin
        lens[r] = $urandom_range(0, 15);
        req_len[r*4 +: 4] = 4'(lens[r]);
      end
      for (int k = 0; k <= 70; k++) begin
        rdy[k]   = ($urandom_range(0, 9) < 7);
        exp_g[k] = 4'h0;
      end
      c = 2; ptr = 0;
      while (c <= 64) begin
        found = 1'b0; i = 0;
        for (int s = 0; s < 4; s++) begin
          if (!found && req[(ptr + s) % 4] && lens[(ptr + s) % 4] != 0) begin
            found = 1'b1;
            i = (ptr + s) % 4;
          end
        end
        if (!found) break;
        lim = (lens[i] > 8) ? 8 : lens[i];
        beats = 0; kk = c;
        forever begin
          exp_g[kk] = 4'(1 << i);
          if (rdy[kk]) beats++;
          if (beats == lim || kk == 64) break;
          kk++;
        end
        ptr = (i + 1) % 4;
        c = kk + 2;
      end
      mem_ready = rdy[0];
      delta_tick = 1'b1; tick(); delta_tick = 1'b0;
      for (int k = 1; k <= 66; k++) begin
        mem_ready = rdy[k];
        chk($sformatf("rand%0d_gnt_c%0d", trial, k), gnt, exp_g[k]);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
